irq_ctrl_n: RTL and testbench

- Parametrised nested-interrupt controller for the single-cycle MIPS core; next generation of the fixed 3-line interrupt logic.
- Sits between the external interrupt pins, the PC unit and the banked register file.
- Latches edge-triggered requests on NUM_IRQ channels and applies a per-channel mask and strict priority; higher index means higher priority.
- On take: redirects the PC to a per-channel vector, saves the return PC per nesting level, and pulses register-bank backup. On the channel's "done" instruction: pulses restore and returns.

---
 rtl/irq_ctrl_n.sv | 146 ++++++++++++++
 tb/tb_irq_ctrl_n.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl_n.sv
// Nested, strictly prioritised interrupt controller for the single-cycle MIPS core.
// It latches request edges, redirects the PC to per-channel vectors and returns through the saved PCs on each channel's done opcode.
`timescale 1ns/1ps
module irq_ctrl_n #(
  parameter int          NUM_IRQ    = 3,
  parameter int          PC_W       = 32,
  parameter logic [31:0] DONE_BASE  = 32'h11111111,
  parameter logic [31:0] VEC_BASE   = 32'h00000100,
  parameter logic [31:0] VEC_STRIDE = 32'h00000040
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               pc_en,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [31:0]        instr,
  input  logic [PC_W-1:0]    pc_next,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  output logic               pc_redirect,
  output logic [PC_W-1:0]    pc_target,
  output logic [NUM_IRQ-1:0] running,
  output logic [NUM_IRQ:0]   backup_en,
  output logic [NUM_IRQ:0]   restore_en,
  output logic [NUM_IRQ-1:0] pending,
  output logic [3:0]         depth
);

  typedef logic [3:0] level_t;

  logic [NUM_IRQ-1:0] irq_q, irq_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] active_q, active_d;
  logic [PC_W-1:0]    save_pc_q [NUM_IRQ+1];
  logic [PC_W-1:0]    save_pc_d [NUM_IRQ+1];

  level_t             level, ret_level, cand_idx;
  logic               cand_valid, done, take;
  logic [NUM_IRQ-1:0] edges, take_oh, active_popped;
  logic [31:0]        done_code;
  logic [PC_W-1:0]    vec_target, ret_pc;
  level_t             depth_cnt;

  // Level of a channel set: 0 when empty, else index of the highest set bit plus one.
  function automatic level_t level_of(input logic [NUM_IRQ-1:0] v);
    level_t l;
    l = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (v[i]) l = level_t'(i + 1);
    end
    return l;
  endfunction

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    level      = level_of(active_q);
    cand_valid = 1'b0;
    cand_idx   = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (pending_q[k] && mask_q[k]) begin
        cand_valid = 1'b1;
        cand_idx   = level_t'(k);
      end
    end

    done_code = DONE_BASE * 32'(level);
    done      = (level != '0) && pc_en && (instr == done_code);
    take      = pc_en && !done && cand_valid && ((cand_idx + level_t'(1)) > level);

    take_oh       = '0;
    active_popped = active_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (level_t'(i) == cand_idx)     take_oh[i]       = 1'b1;
      if (level_t'(i + 1) == level)    active_popped[i] = 1'b0;
    end
    ret_level  = level_of(active_popped);
    vec_target = PC_W'(VEC_BASE + VEC_STRIDE * 32'(cand_idx));

    ret_pc = '0;
    for (int i = 0; i <= NUM_IRQ; i++) begin
      if (level_t'(i) == ret_level) ret_pc = save_pc_q[i];
    end
  end

  // Next-state logic; a fresh edge on the channel being taken re-arms it.
  always_comb begin
    edges     = irq_in & ~irq_q;
    irq_d     = irq_in;
    pending_d = (pending_q & ~(take ? take_oh : '0)) | edges;
    mask_d    = mask_we ? mask_wdata : mask_q;

    if (take)      active_d = active_q | take_oh;
    else if (done) active_d = active_popped;
    else           active_d = active_q;

    for (int i = 0; i <= NUM_IRQ; i++) begin
      save_pc_d[i] = save_pc_q[i];
      if (take && level_t'(i) == level) save_pc_d[i] = pc_next;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!clr) begin
      irq_q     <= '0;
      pending_q <= '0;
      mask_q    <= '1;
      active_q  <= '0;
      // NOTE: the return-PC file is small and its contents are observable after
      // a reset, so it is cleared here rather than left unreset like a RAM.
      for (int i = 0; i <= NUM_IRQ; i++) save_pc_q[i] <= '0;
    end else begin
      irq_q     <= irq_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      active_q  <= active_d;
      for (int i = 0; i <= NUM_IRQ; i++) save_pc_q[i] <= save_pc_d[i];
    end
  end

  // Outputs are forced to zero for as long as clr is held low.
  always_comb begin
    depth_cnt = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (active_q[i]) depth_cnt = depth_cnt + level_t'(1);
    end

    pc_redirect = clr && (take || done);
    if (!clr)      pc_target = '0;
    else if (take) pc_target = vec_target;
    else if (done) pc_target = ret_pc;
    else           pc_target = pc_next;

    for (int i = 0; i <= NUM_IRQ; i++) begin
      backup_en[i]  = clr && take && (level_t'(i) == level);
      restore_en[i] = clr && done && (level_t'(i) == ret_level);
    end

    running = clr ? active_q  : '0;
    pending = clr ? pending_q : '0;
    depth   = clr ? depth_cnt : '0;
  end

endmodule

// File: tb/tb_irq_ctrl_n.sv
// Bench for irq_ctrl_n: a nesting-stack reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_irq_ctrl_n;

  localparam int N = 3;

  logic          clk = 1'b0;
  logic          clr, pc_en, mask_we;
  logic [N-1:0]  irq_in, mask_wdata;
  logic [31:0]   instr, pc_next;
  logic          pc_redirect;
  logic [31:0]   pc_target;
  logic [N-1:0]  running, pending;
  logic [N:0]    backup_en, restore_en;
  logic [3:0]    depth;

  int n_checks = 0;
  int n_errors = 0;

  irq_ctrl_n #(
    .NUM_IRQ(N), .PC_W(32), .DONE_BASE(32'h11111111),
    .VEC_BASE(32'h00000100), .VEC_STRIDE(32'h00000040)
  ) dut (
    .clk(clk), .clr(clr), .pc_en(pc_en), .irq_in(irq_in), .instr(instr),
    .pc_next(pc_next), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .pc_redirect(pc_redirect), .pc_target(pc_target), .running(running),
    .backup_en(backup_en), .restore_en(restore_en), .pending(pending), .depth(depth)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: interrupt nesting as a stack of frames.
  typedef struct {
    int          ch;
    logic [31:0] ret_pc;
    int          prev_level;
  } frame_t;

  frame_t      stk[$];
  logic [N-1:0] m_pending = '0;
  logic [N-1:0] m_irq_q   = '0;
  logic [N-1:0] m_mask    = '1;

  always @(negedge clk) begin : cmp
    int          lvl, cand;
    bit          e_take, e_done;
    logic [63:0] prod;
    logic        e_redirect;
    logic [31:0] e_target;
    logic [N:0]  e_bk, e_rs;
    logic [N-1:0] e_run, e_pend;
    logic [3:0]  e_depth;
    frame_t      f;

    lvl = (stk.size() == 0) ? 0 : stk[$].ch + 1;
    prod = 64'(lvl) * 64'h11111111;
    cand = -1;
    for (int k = 0; k < N; k++) if (m_pending[k] && m_mask[k]) cand = k;
    e_done = clr && lvl != 0 && pc_en && instr == prod[31:0];
    e_take = clr && pc_en && !e_done && cand >= 0 && (cand + 1) > lvl;

    e_redirect = e_take || e_done;
    e_bk = '0;
    e_rs = '0;
    if (!clr)        e_target = '0;
    else if (e_take) begin
      e_target = 32'h100 + 32'(cand) * 32'h40;
      e_bk[lvl] = 1'b1;
    end else if (e_done) begin
      e_target = stk[$].ret_pc;
      e_rs[stk[$].prev_level] = 1'b1;
    end else e_target = pc_next;
    e_run = '0;
    foreach (stk[i]) e_run[stk[i].ch] = 1'b1;
    e_depth = 4'(stk.size());
    e_pend  = m_pending;
    if (!clr) begin
      e_run = '0; e_depth = '0; e_pend = '0;
    end

    check("pc_redirect", 64'(pc_redirect), 64'(e_redirect));
    check("pc_target",   64'(pc_target),   64'(e_target));
    check("backup_en",   64'(backup_en),   64'(e_bk));
    check("restore_en",  64'(restore_en),  64'(e_rs));
    check("running",     64'(running),     64'(e_run));
    check("pending",     64'(pending),     64'(e_pend));
    check("depth",       64'(depth),       64'(e_depth));

    // Advance the model to the state after the coming rising edge.
    if (!clr) begin
      stk.delete();
      m_pending = '0;
      m_irq_q   = '0;
      m_mask    = '1;
    end else begin
      if (e_take) begin
        m_pending[cand] = 1'b0;
        f.ch = cand; f.ret_pc = pc_next; f.prev_level = lvl;
        stk.push_back(f);
      end
      if (e_done) void'(stk.pop_back());
      m_pending = m_pending | (irq_in & ~m_irq_q);
      m_irq_q   = irq_in;
      if (mask_we) m_mask = mask_wdata;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b0; pc_en = 1'b1; irq_in = 3'b111; instr = '0;
    pc_next = 32'h20; mask_we = 1'b0; mask_wdata = '0;
    #1;

    // Reset held with all requests high.
    at_neg(); check("rst_redirect", 64'(pc_redirect), 64'd0);
    check("rst_running", 64'(running), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    cyc(); cyc();
    at_neg(); check("rst_pending_hold", 64'(pending), 64'd0);
    check("rst_target", 64'(pc_target), 64'd0);
    cyc();
    irq_in = '0; clr = 1'b1;
    at_neg(); check("rel_pending", 64'(pending), 64'd0);
    cyc();

    // Single interrupt on channel 0.
    irq_in = 3'b001; pc_next = 32'h20;
    at_neg(); check("single_pulse_noredir", 64'(pc_redirect), 64'd0);
    cyc();
    irq_in = '0; pc_next = 32'h24;
    at_neg(); check("single_redir", 64'(pc_redirect), 64'd1);
    check("single_vec", 64'(pc_target), 64'h100);
    check("single_backup", 64'(backup_en), 64'b0001);
    cyc();
    pc_next = 32'h104;
    at_neg(); check("single_running", 64'(running), 64'b001);
    check("single_depth", 64'(depth), 64'd1);
    cyc();
    instr = 32'h11111111;
    at_neg(); check("single_ret", 64'(pc_target), 64'h24);
    check("single_restore", 64'(restore_en), 64'b0001);
    cyc();
    instr = '0; pc_next = 32'h28;
    at_neg(); check("single_idle", 64'(running), 64'd0);
    cyc();

    // Nesting: channel 2 preempts channel 0.
    irq_in = 3'b001; pc_next = 32'h40; cyc();
    irq_in = '0; pc_next = 32'h50; cyc();
    irq_in = 3'b100; pc_next = 32'h104; cyc();
    irq_in = '0; pc_next = 32'h108;
    at_neg(); check("nest_vec", 64'(pc_target), 64'h180);
    check("nest_backup", 64'(backup_en), 64'b0010);
    cyc();
    pc_next = 32'h184;
    at_neg(); check("nest_running", 64'(running), 64'b101);
    check("nest_depth", 64'(depth), 64'd2);
    cyc();
    instr = 32'h33333333;
    at_neg(); check("nest_ret2", 64'(pc_target), 64'h108);
    check("nest_restore2", 64'(restore_en), 64'b0010);
    cyc();
    instr = 32'h11111111; pc_next = 32'h10c;
    at_neg(); check("nest_ret0", 64'(pc_target), 64'h50);
    check("nest_restore0", 64'(restore_en), 64'b0001);
    cyc();
    instr = '0;
    at_neg(); check("nest_idle", 64'(running), 64'd0);
    cyc();

    // Priority: channel 1 waits behind running channel 2.
    irq_in = 3'b100; pc_next = 32'h60; cyc();
    irq_in = '0; pc_next = 32'h64; cyc();
    irq_in = 3'b010; pc_next = 32'h184; cyc();
    irq_in = '0; pc_next = 32'h188;
    at_neg(); check("prio_pending", 64'(pending), 64'b010);
    check("prio_noredir", 64'(pc_redirect), 64'd0);
    cyc();
    instr = 32'h22222222;
    at_neg(); check("prio_foreign_done", 64'(pc_redirect), 64'd0);
    cyc();
    instr = 32'h33333333;
    at_neg(); check("prio_ret", 64'(pc_target), 64'h64);
    cyc();
    instr = '0; pc_next = 32'h68;
    at_neg(); check("prio_take1", 64'(pc_target), 64'h140);
    check("prio_backup", 64'(backup_en), 64'b0001);
    cyc();
    instr = 32'h11111111;
    at_neg(); check("prio_lower_done", 64'(pc_redirect), 64'd0);
    cyc();
    instr = 32'h22222222;
    at_neg(); check("prio_ret1", 64'(pc_target), 64'h68);
    cyc();
    instr = '0;

    // Mask: channel 0 disabled, request retained, then enabled.
    mask_we = 1'b1; mask_wdata = 3'b110; cyc();
    mask_we = 1'b0; irq_in = 3'b001; pc_next = 32'h70; cyc();
    irq_in = '0; cyc();
    at_neg(); check("mask_pending", 64'(pending), 64'b001);
    check("mask_noredir", 64'(pc_redirect), 64'd0);
    cyc(); cyc();
    mask_we = 1'b1; mask_wdata = 3'b111;
    at_neg(); check("mask_write_cycle", 64'(pc_redirect), 64'd0);
    cyc();
    mask_we = 1'b0; pc_next = 32'h74;
    at_neg(); check("mask_take", 64'(pc_target), 64'h100);
    cyc();
    irq_in = 3'b001; cyc();
    irq_in = '0;
    at_neg(); check("rerun_pending", 64'(pending), 64'b001);
    check("rerun_wait", 64'(pc_redirect), 64'd0);
    cyc();
    instr = 32'h11111111;
    at_neg(); check("rerun_ret", 64'(pc_target), 64'h74);
    cyc();
    instr = '0; pc_next = 32'h78;
    at_neg(); check("rerun_take", 64'(pc_target), 64'h100);
    cyc();
    instr = 32'h11111111; cyc();
    instr = '0;

    // Stall and done/take simultaneity.
    pc_en = 1'b0; irq_in = 3'b010; pc_next = 32'h80; cyc();
    irq_in = '0;
    at_neg(); check("stall_pending", 64'(pending), 64'b010);
    check("stall_noredir", 64'(pc_redirect), 64'd0);
    cyc();
    pc_en = 1'b1;
    at_neg(); check("stall_take", 64'(pc_target), 64'h140);
    cyc();
    pc_en = 1'b0; irq_in = 3'b100; cyc();
    irq_in = '0; pc_en = 1'b1; instr = 32'h22222222; pc_next = 32'h148;
    at_neg(); check("sim_pending2", 64'(pending), 64'b100);
    check("sim_done_first", 64'(pc_target), 64'h80);
    check("sim_restore", 64'(restore_en), 64'b0001);
    cyc();
    instr = '0; pc_next = 32'h84;
    at_neg(); check("sim_take2", 64'(pc_target), 64'h180);
    check("sim_backup", 64'(backup_en), 64'b0001);
    cyc();
    instr = 32'h33333333; irq_in = 3'b001;
    at_neg(); check("edge_done", 64'(pc_target), 64'h84);
    cyc();
    irq_in = '0; instr = '0; pc_next = 32'h88;
    at_neg(); check("edge_take", 64'(pc_target), 64'h100);
    cyc();

    // Reset in the middle of an ISR drops nesting without a restore.
    clr = 1'b0;
    at_neg(); check("midrst_running", 64'(running), 64'd0);
    check("midrst_restore", 64'(restore_en), 64'd0);
    cyc(); cyc();
    clr = 1'b1;
    at_neg(); check("midrst_after", 64'(depth), 64'd0);
    cyc();

    // A level held high requests only once.
    irq_in = 3'b010; pc_next = 32'h90; cyc();
    pc_next = 32'h94;
    at_neg(); check("level_take", 64'(pc_target), 64'h140);
    cyc();
    instr = 32'h22222222;
    at_neg(); check("level_ret", 64'(pc_target), 64'h94);
    cyc();
    instr = '0;
    at_neg(); check("level_no_retake", 64'(pc_redirect), 64'd0);
    check("level_no_pending", 64'(pending), 64'd0);
    cyc();
    irq_in = '0; cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
